udma_smi_slave: RTL

MDIO/SMI management responder (PHY side), the counterpart of the uDMA SMI master. It oversamples MDC/MDIO in the system clock domain and decodes Clause-22 frames (preamble, ST, OP, PHYAD, REGAD, TA, DATA). It maps reads and writes onto a 32 x 16-bit register-port interface and drives MDIO during read data phases. It is used as an on-chip loopback target and in verification environments.

---
 rtl/udma_smi_slave.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/udma_smi_slave.sv
// udma_smi_slave: Clause-22 MDIO/SMI responder mapping frames onto a 32x16 register port.
// Optional macro SMI_SLV_BROADCAST_EN: accept PHYAD 0 as a broadcast address for writes.
`timescale 1ns/1ps
module udma_smi_slave #(
   parameter int PREAMBLE_LEN = 32,
   parameter int SYNC_STAGES  = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        mdc_i,
   input  logic        mdio_i,
   output logic        mdo_o,
   output logic        md_oen_o,
   input  logic [4:0]  phy_addr_i,
   output logic [4:0]  reg_addr_o,
   output logic        reg_rd_o,
   input  logic [15:0] reg_rdata_i,
   output logic        reg_wr_o,
   output logic [15:0] reg_wdata_o,
   output logic        busy_o,
   output logic        frame_err_o
);

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_TA, S_DATA} state_t;

   localparam logic [5:0] PRE = 6'(PREAMBLE_LEN);

   state_t                 state_q, state_n;
   logic [SYNC_STAGES-1:0] mdc_sync, mdio_sync;
   logic                   mdc_prev;
   logic                   mdc_s, mdio_s, rise;
   logic [5:0]             pre_q;
   logic [4:0]             bit_q;
   logic [3:0]             hdr_q;
   logic                   is_rd_q;
   logic [15:0]            dat_q;
   logic                   rd_q;
   logic [1:0]             op_c;
   logic [4:0]             fld_c;
   logic                   adr_ok, err, drop, do_rd, ta_drv, sh_out, rel, do_wr;

   assign mdc_s  = mdc_sync[SYNC_STAGES-1];
   assign mdio_s = mdio_sync[SYNC_STAGES-1];
   assign rise   = mdc_s & ~mdc_prev;
   assign op_c   = {hdr_q[0], mdio_s};
   assign fld_c  = {hdr_q, mdio_s};
   assign busy_o = (state_q != S_IDLE);

   // Synchronize MDC/MDIO into clk_i and keep last MDC for edge detect
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mdc_sync  <= '1;
         mdio_sync <= '1;
         mdc_prev  <= 1'b1;
      end else begin
         mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], mdc_i};
         mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], mdio_i};
         mdc_prev  <= mdc_s;
      end
   end

   // Next-state and per-bit actions, evaluated only on an MDC rise
   always_comb begin
      state_n = state_q;
      err     = 1'b0;
      drop    = 1'b0;
      do_rd   = 1'b0;
      ta_drv  = 1'b0;
      sh_out  = 1'b0;
      rel     = 1'b0;
      do_wr   = 1'b0;
      adr_ok  = (fld_c == phy_addr_i);
`ifdef SMI_SLV_BROADCAST_EN
      if (fld_c == 5'd0 && !is_rd_q) adr_ok = 1'b1;
`endif
      if (rise) begin
         unique case (state_q)
            S_IDLE: begin
               if (!mdio_s && pre_q == PRE) state_n = S_HDR;
            end
            S_HDR: begin
               if (bit_q == 5'd1 && !mdio_s) err = 1'b1;
               else if (bit_q == 5'd3 && (op_c == 2'b00 || op_c == 2'b11)) err = 1'b1;
               else if (bit_q == 5'd8 && !adr_ok) drop = 1'b1;
               else if (bit_q == 5'd13) begin
                  state_n = S_TA;
                  do_rd   = is_rd_q;
               end
            end
            S_TA: begin
               if (bit_q == 5'd14) begin
                  if (is_rd_q) ta_drv = 1'b1;
                  else if (!mdio_s) err = 1'b1;
               end else begin
                  if (is_rd_q) sh_out = 1'b1;
                  else if (mdio_s) err = 1'b1;
                  state_n = S_DATA;
               end
            end
            S_DATA: begin
               if (bit_q == 5'd31) begin
                  state_n = S_IDLE;
                  rel     = is_rd_q;
                  do_wr   = !is_rd_q;
               end else begin
                  sh_out = is_rd_q;
               end
            end
         endcase
         if (err || drop) state_n = S_IDLE;
      end
   end

   // Frame state, shift registers, register-port strobes and MDIO drive
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         pre_q       <= '0;
         bit_q       <= '0;
         hdr_q       <= '0;
         is_rd_q     <= 1'b0;
         dat_q       <= '0;
         rd_q        <= 1'b0;
         mdo_o       <= 1'b1;
         md_oen_o    <= 1'b0;
         reg_addr_o  <= '0;
         reg_rd_o    <= 1'b0;
         reg_wr_o    <= 1'b0;
         reg_wdata_o <= '0;
         frame_err_o <= 1'b0;
      end else begin
         state_q     <= state_n;
         reg_rd_o    <= 1'b0;
         reg_wr_o    <= 1'b0;
         frame_err_o <= err;
         rd_q        <= reg_rd_o;
         if (rd_q) dat_q <= reg_rdata_i;
         if (rise) begin
            bit_q <= (state_q == S_IDLE) ? 5'd1 : bit_q + 5'd1;
            if (state_q == S_IDLE)
               pre_q <= !mdio_s ? 6'd0 : (pre_q == PRE) ? pre_q : pre_q + 6'd1;
            if (state_q == S_HDR && bit_q >= 5'd2) hdr_q <= {hdr_q[2:0], mdio_s};
            if (state_q == S_HDR && bit_q == 5'd3) is_rd_q <= (op_c == 2'b10);
            if (state_q == S_HDR && bit_q == 5'd13) reg_addr_o <= fld_c;
            if (do_rd) reg_rd_o <= 1'b1;
            if (ta_drv) begin
               md_oen_o <= 1'b1;
               mdo_o    <= 1'b0;
            end
            if (sh_out) begin
               mdo_o <= dat_q[15];
               dat_q <= {dat_q[14:0], 1'b0};
            end
            if (state_q == S_DATA && !is_rd_q) dat_q <= {dat_q[14:0], mdio_s};
            if (rel) begin
               md_oen_o <= 1'b0;
               mdo_o    <= 1'b1;
            end
            if (do_wr) begin
               reg_wr_o    <= 1'b1;
               reg_wdata_o <= {dat_q[14:0], mdio_s};
            end
         end
         if (state_q != S_IDLE && state_n == S_IDLE) pre_q <= '0;
      end
   end

endmodule
